// File: rtl/divider_taint_pkg.sv
// ----------------------------------------------------------------------------
// divider_taint_pkg : shared state encoding and sizing helpers for the
//                     taint-tracked restoring divider.   rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package divider_taint_pkg;

  localparam int STATE_WIDTH = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Iteration counter width; never below one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/divider_taint_datapath.sv
// ----------------------------------------------------------------------------
// divider_taint_datapath : dividend/divisor/remainder/quotient registers, the
//                          restoring subtract step and their taint shadows. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module divider_taint_datapath
  import divider_taint_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             iter,
  input  logic             zero_load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] dividend_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] divisor_t,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] quotient_t,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] remainder_t
);

  logic [WIDTH-1:0] dvd_q, dvd_d, dvd_t_q, dvd_t_d;
  logic [WIDTH-1:0] dvs_q, dvs_d, dvs_t_q, dvs_t_d;
  logic [WIDTH-1:0] rem_q, rem_d, rem_t_q, rem_t_d;
  logic [WIDTH-1:0] quo_q, quo_d, quo_t_q, quo_t_d;

  logic [WIDTH-1:0] sh, sh_t, diff;
  logic             ge, cmp_t;

  always_comb begin
    sh    = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    sh_t  = {rem_t_q[WIDTH-2:0], dvd_t_q[WIDTH-1]};
    ge    = (sh >= dvs_q);
    diff  = sh - dvs_q;
    // The compare outcome depends on every bit of both operands.
    cmp_t = (|sh_t) | (|dvs_t_q);

    dvd_d   = dvd_q;
    dvd_t_d = dvd_t_q;
    dvs_d   = dvs_q;
    dvs_t_d = dvs_t_q;
    rem_d   = rem_q;
    rem_t_d = rem_t_q;
    quo_d   = quo_q;
    quo_t_d = quo_t_q;

    if (load) begin
      dvd_d   = dividend;
      dvd_t_d = dividend_t;
      dvs_d   = divisor;
      dvs_t_d = divisor_t;
      rem_d   = '0;
      rem_t_d = '0;
      quo_d   = '0;
      quo_t_d = '0;
      if (zero_load) begin
        quo_d   = '1;
        quo_t_d = '1;
        rem_d   = dividend;
        rem_t_d = '1;
      end
    end else if (iter) begin
      dvd_d   = {dvd_q[WIDTH-2:0], 1'b0};
      dvd_t_d = {dvd_t_q[WIDTH-2:0], 1'b0};
      rem_d   = ge ? diff : sh;
      rem_t_d = {WIDTH{cmp_t}};
      quo_d   = {quo_q[WIDTH-2:0], ge};
      quo_t_d = {quo_t_q[WIDTH-2:0], cmp_t};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q   <= '0;
      dvd_t_q <= '0;
      dvs_q   <= '0;
      dvs_t_q <= '0;
      rem_q   <= '0;
      rem_t_q <= '0;
      quo_q   <= '0;
      quo_t_q <= '0;
    end else begin
      dvd_q   <= dvd_d;
      dvd_t_q <= dvd_t_d;
      dvs_q   <= dvs_d;
      dvs_t_q <= dvs_t_d;
      rem_q   <= rem_d;
      rem_t_q <= rem_t_d;
      quo_q   <= quo_d;
      quo_t_q <= quo_t_d;
    end
  end

  assign quotient    = quo_q;
  assign quotient_t  = quo_t_q;
  assign remainder   = rem_q;
  assign remainder_t = rem_t_q;

endmodule

`default_nettype wire

// File: rtl/divider_taint_track.sv
// ----------------------------------------------------------------------------
// divider_taint_track : sequential restoring divider with conservative taint
//                       tracking; optional divide-by-zero shortcut under
//                       DIVIDER_ZERO_CHECK_EN.   rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module divider_taint_track
  import divider_taint_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] dividend_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] divisor_t,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] quotient_t,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] remainder_t,
  output logic             busy,
  output logic             busy_t,
  output logic             done,
  output logic             done_t
`ifdef DIVIDER_ZERO_CHECK_EN
  ,
  output logic             div_by_zero,
  output logic             div_by_zero_t
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_t_q, state_t_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             load, iter, zero_load;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    state_t_d = state_t_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    load      = 1'b0;
    iter      = 1'b0;
    zero_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_t_d = 1'b0;
        if (start) begin
          state_d   = ST_LOAD;
          busy_d    = 1'b1;
          state_t_d = start_t;
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        cnt_d   = '0;
        state_d = ST_ITER;
`ifdef DIVIDER_ZERO_CHECK_EN
        // The branch taken depends on the divisor value, so its taint reaches control.
        state_t_d = state_t_q | (|divisor_t);
        if (divisor == '0) begin
          zero_load = 1'b1;
          state_d   = ST_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          dz_d      = 1'b1;
        end
`endif
      end
      ST_ITER: begin
        iter  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        state_t_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      state_t_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      state_t_q <= state_t_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  divider_taint_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .iter       (iter),
    .zero_load  (zero_load),
    .dividend   (dividend),
    .dividend_t (dividend_t),
    .divisor    (divisor),
    .divisor_t  (divisor_t),
    .quotient   (quotient),
    .quotient_t (quotient_t),
    .remainder  (remainder),
    .remainder_t(remainder_t)
  );

  assign busy   = busy_q;
  assign busy_t = state_t_q;
  assign done   = done_q;
  assign done_t = state_t_q;

`ifdef DIVIDER_ZERO_CHECK_EN
  assign div_by_zero   = dz_q;
  assign div_by_zero_t = state_t_q;
`else
  logic unused_dz;
  assign unused_dz = dz_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_divider_taint_track.sv
// ----------------------------------------------------------------------------
// tb_divider_taint_track : directed table plus randomized checks of the
//                          taint-tracked divider against a behavioural model.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_divider_taint_track;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         start_t = 1'b0;
  logic [W-1:0] dividend = '0, dividend_t = '0, divisor = '0, divisor_t = '0;
  logic [W-1:0] quotient, quotient_t, remainder, remainder_t;
  logic         busy, busy_t, done, done_t;
`ifdef DIVIDER_ZERO_CHECK_EN
  logic         div_by_zero, div_by_zero_t;
`endif

  divider_taint_track #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_t    (start_t),
    .dividend   (dividend),
    .dividend_t (dividend_t),
    .divisor    (divisor),
    .divisor_t  (divisor_t),
    .quotient   (quotient),
    .quotient_t (quotient_t),
    .remainder  (remainder),
    .remainder_t(remainder_t),
    .busy       (busy),
    .busy_t     (busy_t),
    .done       (done),
    .done_t     (done_t)
`ifdef DIVIDER_ZERO_CHECK_EN
    ,
    .div_by_zero  (div_by_zero),
    .div_by_zero_t(div_by_zero_t)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, at, b, bt;
    logic         st;
    logic [W-1:0] q, qt, r, rt;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit zero_shortcut(input vec_t v);
`ifdef DIVIDER_ZERO_CHECK_EN
    return (v.b == '0);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: plain arithmetic plus taint reasoning. Once any tainted bit enters
  // the partial remainder, every later quotient bit and the remainder are tainted.
  function automatic vec_t model(input vec_t v);
    vec_t e = v;
    if (v.b == '0) begin
      e.q = '1;
      e.r = v.a;
    end else begin
      e.q = v.a / v.b;
      e.r = v.a % v.b;
    end
    e.qt = '0;
    e.rt = '0;
    if (|v.bt || zero_shortcut(v)) begin
      e.qt = '1;
      e.rt = '1;
    end else begin
      for (int i = 0; i < W; i++)
        if (v.at[i]) begin
          e.qt = W'((1 << (i + 1)) - 1);
          e.rt = '1;
        end
    end
    return e;
  endfunction

  function automatic logic exp_ctl_t(input vec_t v);
`ifdef DIVIDER_ZERO_CHECK_EN
    return v.st | (|v.bt);
`else
    return v.st;
`endif
  endfunction

  task automatic run(input vec_t v, input string tag);
    int  lat;
    bit  seen;
    int  exp_lat;
    exp_lat = zero_shortcut(v) ? 1 : W + 1;
    @(negedge clk);
    dividend   = v.a;
    dividend_t = v.at;
    divisor    = v.b;
    divisor_t  = v.bt;
    start      = 1'b1;
    start_t    = v.st;
    @(posedge clk);
    #1;
    start   = 1'b0;
    start_t = 1'b0;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2 && exp_lat > 2) begin
        check({tag, " busy"}, busy, 1'b1);
        check({tag, " busy_t"}, busy_t, exp_ctl_t(v));
      end
      if (done) seen = 1;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " quotient"}, quotient, v.q);
    check({tag, " remainder"}, remainder, v.r);
    check({tag, " quotient_t"}, quotient_t, v.qt);
    check({tag, " remainder_t"}, remainder_t, v.rt);
    check({tag, " done_t"}, done_t, exp_ctl_t(v));
`ifdef DIVIDER_ZERO_CHECK_EN
    check({tag, " div_by_zero"}, div_by_zero, zero_shortcut(v));
`endif
    @(posedge clk);
    #1;
    check({tag, " done pulse width"}, done, 1'b0);
    check({tag, " idle busy_t"}, busy_t, 1'b0);
    check({tag, " quotient hold"}, quotient, v.q);
  endtask

  vec_t tbl[7];

  initial begin
    vec_t v;
    int   t1, t2;
    bit   got;

    //       a      at       b      bt      st    q        qt       r      rt
    tbl[0] = '{4'd13, 4'b0000, 4'd3, 4'b0000, 1'b0, 4'd4,  4'b0000, 4'd1, 4'b0000};
    tbl[1] = '{4'd13, 4'b0001, 4'd3, 4'b0000, 1'b0, 4'd4,  4'b0001, 4'd1, 4'b1111};
    tbl[2] = '{4'd13, 4'b0000, 4'd3, 4'b0001, 1'b0, 4'd4,  4'b1111, 4'd1, 4'b1111};
    tbl[3] = '{4'd7,  4'b0000, 4'd2, 4'b0000, 1'b1, 4'd3,  4'b0000, 4'd1, 4'b0000};
    tbl[4] = '{4'd9,  4'b0000, 4'd0, 4'b0000, 1'b0, 4'hF,  4'b0000, 4'd9, 4'b0000};
    tbl[5] = '{4'd15, 4'b0000, 4'd1, 4'b0000, 1'b0, 4'd15, 4'b0000, 4'd0, 4'b0000};
    tbl[6] = '{4'd8,  4'b0100, 4'd5, 4'b0000, 1'b0, 4'd1,  4'b0111, 4'd3, 4'b1111};
`ifdef DIVIDER_ZERO_CHECK_EN
    tbl[4].qt = 4'b1111;
    tbl[4].rt = 4'b1111;
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset quotient", quotient, 0);
    check("reset remainder_t", remainder_t, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.a  = W'($urandom);
      v.b  = W'($urandom);
      v.at = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      v.bt = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      v.st = 1'($urandom);
      v = model(v);
      run(v, $sformatf("rnd%0d", i));
    end

    // Back-to-back: start held high; the edge leaving DONE must be ignored.
    @(negedge clk);
    dividend = 4'd13; dividend_t = '0; divisor = 4'd3; divisor_t = '0;
    start = 1'b1; start_t = 1'b0;
    t1 = -1; t2 = -1; got = 0;
    for (int c = 0; c < 40 && t2 < 0; c++) begin
      @(posedge clk);
      #1;
      if (done && !got) begin
        if (t1 < 0) t1 = c; else t2 = c;
      end
      got = done;
    end
    start = 1'b0;
    check("b2b done spacing", t2 - t1, W + 3);
    check("b2b second quotient", quotient, 4);
    repeat (3) @(posedge clk);

    // Asynchronous reset during the second ITER cycle of 15/1.
    @(negedge clk);
    dividend = 4'd15; dividend_t = 4'b0010; divisor = 4'd1; divisor_t = 4'b0001;
    start = 1'b1; start_t = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; start_t = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    check("pre-reset busy", busy, 1'b1);
    check("pre-reset quotient", quotient, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("async quotient", quotient, 0);
    check("async quotient_t", quotient_t, 0);
    check("async remainder", remainder, 0);
    check("async remainder_t", remainder_t, 0);
    check("async busy", busy, 0);
    check("async busy_t", busy_t, 0);
    check("async done", done, 0);
    check("async done_t", done_t, 0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{4'd6, 4'b0000, 4'd4, 4'b0000, 1'b0, 4'd1, 4'b0000, 4'd2, 4'b0000};
    run(v, "post-reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
